rand_arbiter: RTL and testbench
===============================

# rand_arbiter

Shared random-number server for the finalwork datapath. Holds one 32-bit Fibonacci-style LFSR, with the same polynomial and reset seed as the existing generator. Several consumers request words through a level-request / one-cycle-valid handshake, and a round-robin arbiter picks which one is served next. Between grants the LFSR is stirred a programmable number of steps, so consecutive consumers never receive adjacent sequence values.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- STEPS, 8: LFSR shifts per served word, ≥1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  reset; asynchronous and active-low.
- req  in  N_REQ  level request per consumer; hold high until served.
- rvalid  out  N_REQ  one-hot; high for exactly one cycle when the corresponding consumer's word is on rdata.
- rdata  out  32 signed  current LFSR register; meaningful only while any rvalid bit is high.
- busy  out  1  high in STIR and DELIVER.
- seed_load  in  1  seed strobe; active only with RAND_SEED_LOAD_EN.
- seed  in  32  seed value sampled on seed_load.

## Operation
- LFSR update per shift: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[0]}.
- Reset value of lfsr is 32'h0000ACE1.
- The LFSR holds its value in IDLE; it shifts only in STIR.
- Registers: state, lfsr, cnt (width clog2(STEPS)+1), gidx (grant index), last (round-robin pointer).
- Reset values:
  - state = IDLE, last = N_REQ-1, gidx = 0, cnt = 0.
  - rvalid = 0, busy = 0, rdata = 32'h0000ACE1.
- FSM states:
  - IDLE:
    - If seed_load is accepted, load the seed and stay in IDLE.
    - Else if req != 0: gidx <= winner, last <= winner, cnt <= STEPS-1, go to STIR.
  - STIR:
    - Shift lfsr every cycle.
    - If req[gidx] is low at the edge, abort: go to IDLE, no rvalid. Shifts already taken are kept, and last stays updated.
    - Else if cnt == 0, go to DELIVER; otherwise cnt <= cnt-1.
  - DELIVER: rvalid[gidx] = 1; the next edge returns to IDLE unconditionally.
- Winner: the first index with req set, scanning last+1, last+2, … modulo N_REQ.
  - A single persistent requester is re-served every STEPS+2 cycles.
  - All requesters high are served in the order 0, 1, …, N_REQ-1, 0, …
- rvalid and busy are decoded from the registered state, so they are glitch-free. rdata is wired directly from the lfsr register.
- Requesters must not rely on req dropping during DELIVER; the word is delivered once rvalid is seen.

## Timing
- Request sampled at edge E0 in IDLE:
  - STIR runs for STEPS cycles, E1..E_STEPS.
  - rvalid is high in the cycle after edge E_STEPS.
  - State is back in IDLE after edge E_STEPS+1.
- A new request is accepted at the first edge where state is IDLE.
- Minimum spacing between rvalid pulses is STEPS+2 cycles.
- reset_n low mid-STIR or mid-DELIVER: all registers, including lfsr, return to their reset values immediately. A pending word is lost; rvalid never pulses.

## Configuration
- Macro RAND_SEED_LOAD_EN:
  - Defined:
    - In IDLE, seed_load=1 loads lfsr <= (seed==0) ? 32'h0000ACE1 : seed, because the all-zero state is locked.
    - seed_load has priority over req in the same IDLE cycle; the request is granted one cycle later.
    - seed_load in STIR or DELIVER is ignored.
  - Undefined: seed_load and seed are present but ignored; lfsr is changed only by reset and stirring.

## Test plan
- STEPS=1. Release reset, then hold req=4'b0001. Required: rvalid=4'b0001 for one cycle with rdata=32'h000159C3. Next delivery rdata=32'h0002B387.
- STEPS=8, req=4'b1111 held. Required: rvalid pulses 0001, 0010, 0100, 1000, 0001, spaced exactly 10 cycles apart; busy low for one cycle between pulses.
- STEPS=8, req[2] raised, then dropped on the 3rd STIR cycle. Required: no rvalid; state in IDLE one cycle later. A later req[3] is served with lfsr advanced by 3+8 shifts from its starting value.
- Assert reset_n low during DELIVER. Required: rvalid=0 and busy=0 immediately; rdata=32'h0000ACE1; no rvalid after release until a new request.
- With RAND_SEED_LOAD_EN, STEPS=1:
  - seed_load with seed=0 in IDLE gives rdata=32'h0000ACE1.
  - seed=32'h80000001 then req[1] gives rvalid[1] with rdata=32'h00000002.
  - seed_load during STIR is ignored.
- With RAND_SEED_LOAD_EN: seed_load and req[0] in the same IDLE cycle. Required: seed loaded first; STIR entered one edge later; delivered word derived from the new seed.

Source files
------------

// File: rtl/rand_arbiter_if.sv
// rand_arbiter_if: request/deliver bundle between consumers and the shared random-number server.
// Ports: req (level request per consumer), rvalid (one-hot delivery strobe), rdata (LFSR word),
//        busy (server stirring or delivering), seed_load/seed (optional reseed strobe and value).
interface rand_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rvalid;
  logic signed [31:0] rdata;
  logic busy;
  logic seed_load;
  logic [31:0] seed;

  // Consumer side drives requests and the seed strobe.
  modport master (
    output req,
    output seed_load,
    output seed,
    input  rvalid,
    input  rdata,
    input  busy
  );

  // Server side.
  modport slave (
    input  req,
    input  seed_load,
    input  seed,
    output rvalid,
    output rdata,
    output busy
  );
endinterface

// File: rtl/rand_arbiter.sv
// rand_arbiter: shared 32-bit Fibonacci LFSR served round-robin to N_REQ consumers.
// Latency: request seen in IDLE -> rvalid STEPS+1 cycles later; rvalid pulses spaced >= STEPS+2 cycles.
// Backpressure: consumers hold req high until served; dropping req mid-stir aborts that grant.
// Ports: clk, reset_n (async active-low), bus (rand_arbiter_if.slave: req, rvalid, rdata, busy,
//        seed_load, seed). Optional reseed feature enabled by defining RAND_SEED_LOAD_EN.
module rand_arbiter #(
  parameter int N_REQ = 4,
  parameter int STEPS = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  rand_arbiter_if.slave bus
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(STEPS) + 1;
  localparam logic [31:0] LFSR_SEED = 32'h0000ACE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STIR    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   lfsr, lfsr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [GW-1:0] gidx, gidx_nx;
  logic [GW-1:0] last, last_nx;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          found;
  int            idx;
  logic          seed_go;
  logic [31:0]   seed_val;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[0]};
  endfunction

`ifdef RAND_SEED_LOAD_EN
  // All-zero is a lock-up state for this LFSR, so a zero seed falls back to the reset seed.
  assign seed_go  = bus.seed_load;
  assign seed_val = (bus.seed == 32'd0) ? LFSR_SEED : bus.seed;
`else
  logic unused_seed;
  assign unused_seed = ^{bus.seed_load, bus.seed};
  assign seed_go     = 1'b0;
  assign seed_val    = LFSR_SEED;
`endif

  // Round-robin pick: first requester at last+1, last+2, ... wrapping modulo N_REQ.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = GW'(idx);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    cnt_nx   = cnt;
    gidx_nx  = gidx;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (seed_go) begin
          lfsr_nx = seed_val;
        end else if (|bus.req) begin
          gidx_nx  = winner;
          last_nx  = winner;
          cnt_nx   = CW'(STEPS - 1);
          state_nx = STIR;
        end
      end
      STIR: begin
        // The shift is taken even on the aborting edge; last is left pointing at the aborted grant.
        lfsr_nx = lfsr_step(lfsr);
        if (!bus.req[gidx]) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = DELIVER;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DELIVER: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lfsr  <= LFSR_SEED;
      cnt   <= '0;
      gidx  <= '0;
      last  <= GW'(N_REQ - 1);
    end else begin
      state <= state_nx;
      lfsr  <= lfsr_nx;
      cnt   <= cnt_nx;
      gidx  <= gidx_nx;
      last  <= last_nx;
    end
  end

  // Outputs decode registered state only, so they cannot glitch on req changes.
  always_comb begin
    bus.rvalid = '0;
    if (state == DELIVER) bus.rvalid[gidx] = 1'b1;
  end

  assign bus.busy  = (state != IDLE);
  assign bus.rdata = lfsr;

endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter: directed scoreboard bench for rand_arbiter.
// Two instances: u1 (STEPS=1) and u8 (STEPS=8); expected deliveries are queued per instance
// and popped by a negedge monitor whenever rvalid is seen.
module tb_rand_arbiter;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst8_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q8[$];
  exp_t e1, e8;

  always #5 clk = ~clk;

  rand_arbiter_if #(.N_REQ(4)) if1 ();
  rand_arbiter_if #(.N_REQ(4)) if8 ();

  rand_arbiter #(.N_REQ(4), .STEPS(1)) u1 (.clk(clk), .reset_n(rst1_n), .bus(if1));
  rand_arbiter #(.N_REQ(4), .STEPS(8)) u8 (.clk(clk), .reset_n(rst8_n), .bus(if8));

  function automatic logic [31:0] lstep(input logic [31:0] x, input int n);
    logic [31:0] v;
    v = x;
    for (int k = 0; k < n; k++) v = {v[30:0], v[31] ^ v[0]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [3:0] rv, input logic [31:0] d);
    exp_t e;
    e.rv = rv;
    e.d  = d;
    if (sel) q8.push_back(e);
    else q1.push_back(e);
  endtask

  // Returns at the negedge where the chosen instance shows rvalid, or after budget cycles.
  task automatic wait_pulse(input bit sel, input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? |if8.rvalid : |if1.rvalid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(sel ? |if8.rvalid : |if1.rvalid)) begin
      errors++;
      $display("FAIL %s: no rvalid within %0d cycles, expected a delivery", name, budget);
    end
  endtask

  always @(negedge clk) begin
    if (|if1.rvalid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u1_unexpected: got rvalid=%b rdata=%h, expected no delivery", if1.rvalid, if1.rdata);
      end else begin
        e1 = q1.pop_front();
        check("u1_rvalid", 32'(if1.rvalid), 32'(e1.rv));
        check("u1_rdata", if1.rdata, e1.d);
      end
    end
    if (|if8.rvalid) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u8_unexpected: got rvalid=%b rdata=%h, expected no delivery", if8.rvalid, if8.rdata);
      end else begin
        e8 = q8.pop_front();
        check("u8_rvalid", 32'(if8.rvalid), 32'(e8.rv));
        check("u8_rdata", if8.rdata, e8.d);
      end
    end
  end

  initial begin
    int times[5];
    int n, cyc, idle_cnt;
    logic [31:0] l0;

    if1.req = '0; if1.seed_load = 1'b0; if1.seed = '0;
    if8.req = '0; if8.seed_load = 1'b0; if8.seed = '0;

    // Reset state.
    @(negedge clk);
    check("u1_reset_rvalid", 32'(if1.rvalid), 32'd0);
    check("u1_reset_busy", 32'(if1.busy), 32'd0);
    check("u1_reset_rdata", if1.rdata, 32'h0000ACE1);
    check("u8_reset_rvalid", 32'(if8.rvalid), 32'd0);
    check("u8_reset_busy", 32'(if8.busy), 32'd0);
    check("u8_reset_rdata", if8.rdata, 32'h0000ACE1);
    @(negedge clk);
    rst1_n = 1'b1;
    rst8_n = 1'b1;

    // STEPS=1: persistent single requester, two deliveries.
    @(negedge clk);
    if1.req = 4'b0001;
    push(1'b0, 4'b0001, 32'h000159C3);
    push(1'b0, 4'b0001, 32'h0002B387);
    wait_pulse(1'b0, "u1_first", 10);
    wait_pulse(1'b0, "u1_second", 10);
    if1.req = '0;
    repeat (3) @(negedge clk);

    // Reset during DELIVER: requester 1 wins (last=0), 3rd shift overall gives 0005670F.
    if1.req = 4'b0010;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("u1_deliver_rvalid", 32'(if1.rvalid), 32'h2);
    check("u1_deliver_rdata", if1.rdata, 32'h0005670F);
    rst1_n = 1'b0;
    #1;
    check("u1_rst_rvalid", 32'(if1.rvalid), 32'd0);
    check("u1_rst_busy", 32'(if1.busy), 32'd0);
    check("u1_rst_rdata", if1.rdata, 32'h0000ACE1);
    @(negedge clk);
    if1.req = '0;
    @(negedge clk);
    rst1_n = 1'b1;
    repeat (4) @(negedge clk);
    check("u1_post_rst_busy", 32'(if1.busy), 32'd0);
    // After reset last=N_REQ-1 so requester 0 wins, and the LFSR restarts from ACE1.
    if1.req = 4'b0001;
    push(1'b0, 4'b0001, 32'h000159C3);
    wait_pulse(1'b0, "u1_after_rst", 10);
    if1.req = '0;
    repeat (2) @(negedge clk);

`ifdef RAND_SEED_LOAD_EN
    // Zero seed falls back to ACE1.
    if1.seed_load = 1'b1;
    if1.seed = 32'h0;
    @(negedge clk);
    if1.seed_load = 1'b0;
    check("u1_seed_zero", if1.rdata, 32'h0000ACE1);
    // Seed 80000001 then req[1]: one shift gives 00000002.
    if1.seed_load = 1'b1;
    if1.seed = 32'h80000001;
    @(negedge clk);
    if1.seed_load = 1'b0;
    check("u1_seed_loaded", if1.rdata, 32'h80000001);
    if1.req = 4'b0010;
    push(1'b0, 4'b0010, 32'h00000002);
    wait_pulse(1'b0, "u1_seed_deliver", 10);
    if1.req = '0;
    @(negedge clk);
    // seed_load during STIR is ignored.
    if1.req = 4'b0001;
    push(1'b0, 4'b0001, 32'h00000004);
    @(negedge clk);
    check("u1_stir_busy", 32'(if1.busy), 32'd1);
    if1.seed_load = 1'b1;
    if1.seed = 32'hDEADBEEF;
    wait_pulse(1'b0, "u1_stir_seed", 10);
    if1.seed_load = 1'b0;
    if1.req = '0;
    @(negedge clk);
    // seed_load and req together: seed first, grant one edge later.
    if1.seed_load = 1'b1;
    if1.seed = 32'h12345678;
    if1.req = 4'b0010;
    push(1'b0, 4'b0010, 32'h2468ACF0);
    @(negedge clk);
    if1.seed_load = 1'b0;
    check("u1_seed_prio_busy", 32'(if1.busy), 32'd0);
    @(negedge clk);
    check("u1_seed_then_stir", 32'(if1.busy), 32'd1);
    wait_pulse(1'b0, "u1_seed_prio", 10);
    if1.req = '0;
    repeat (2) @(negedge clk);
`endif

    // STEPS=8: all requesters held, order 0,1,2,3,0, spacing 10.
    if8.req = 4'b1111;
    push(1'b1, 4'b0001, lstep(32'h0000ACE1, 8));
    push(1'b1, 4'b0010, lstep(32'h0000ACE1, 16));
    push(1'b1, 4'b0100, lstep(32'h0000ACE1, 24));
    push(1'b1, 4'b1000, lstep(32'h0000ACE1, 32));
    push(1'b1, 4'b0001, lstep(32'h0000ACE1, 40));
    n = 0;
    cyc = 0;
    idle_cnt = 0;
    while (n < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (|if8.rvalid) begin
        times[n] = cyc;
        n++;
      end else if (n >= 1 && !if8.busy) begin
        idle_cnt++;
      end
    end
    if8.req = '0;
    check("u8_pulse_count", 32'(n), 32'd5);
    check("u8_first_latency", 32'(times[0]), 32'd9);
    for (int i = 1; i < 5; i++) check("u8_spacing", 32'(times[i] - times[i-1]), 32'd10);
    check("u8_idle_gaps", 32'(idle_cnt), 32'd4);
    repeat (3) @(negedge clk);

    // Abort: req[2] dropped in the 3rd STIR cycle; 3 shifts kept.
    l0 = lstep(32'h0000ACE1, 40);
    if8.req = 4'b0100;
    @(negedge clk);
    check("u8_stir_busy", 32'(if8.busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    if8.req = '0;
    @(negedge clk);
    check("u8_abort_idle", 32'(if8.busy), 32'd0);
    check("u8_abort_lfsr", if8.rdata, lstep(l0, 3));
    // last points at 2, so req[3] wins next.
    if8.req = 4'b1000;
    push(1'b1, 4'b1000, lstep(l0, 11));
    wait_pulse(1'b1, "u8_after_abort", 30);
    if8.req = '0;
    repeat (5) @(negedge clk);

    check("u1_queue_empty", 32'(q1.size()), 32'd0);
    check("u8_queue_empty", 32'(q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
